// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / hazard unit.
// Holds the register-file select code, the in-flight tracker entry type and
// the select-width helper used to size per-port select fields.
package fwd_pkg;

   // Select code meaning "read the operand from the register file".
   localparam int SEL_RF = 0;

   // Widest register index the tracker entry can hold. REG_AW of any
   // instance must not exceed this; narrower indices are zero-extended.
   localparam int DEST_W = 16;

   // One in-flight instruction as seen by the hazard logic.
   typedef struct packed {
      logic              valid;
      logic              wb_en;
      logic [DEST_W-1:0] dest;
      logic              is_load;
   } trk_entry_t;

   // Width needed to encode 0 (register file) through depth (oldest stage).
   function automatic int sel_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Per-operand priority matcher: finds the youngest in-flight writer of src.
// Latency: combinational (0 cycles). Backpressure: none, pure function.
// Ports:
//   src, src_valid      - one source register index and its read-enable
//   trk                 - tracker, trk[k-1] is stage k (1 = EX)
//   sel                 - 0 = register file, k = youngest matching stage
//   load_use            - the stage-1 entry matches and is a load
//   any_match           - some stage matches
module fwd_port_sel
   import fwd_pkg::*;
#(
   parameter int REG_AW = 4,
   parameter int DEPTH  = 3,
   parameter int SW     = sel_width(DEPTH)
) (
   input  logic [REG_AW-1:0]      src,
   input  logic                   src_valid,
   input  trk_entry_t [DEPTH-1:0] trk,
   output logic [SW-1:0]          sel,
   output logic                   load_use,
   output logic                   any_match
);

   logic [DEPTH-1:0]  hit;
   logic [DEST_W-1:0] src_ext;

   assign src_ext = DEST_W'(src);

   always_comb begin
      hit = '0;
      for (int k = 0; k < DEPTH; k++) begin
         hit[k] = trk[k].valid && trk[k].wb_en && src_valid &&
                  (trk[k].dest == src_ext);
      end
   end

   // Scan oldest to youngest so the youngest hit overwrites older ones.
   always_comb begin
      sel = SW'(SEL_RF);
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (hit[k]) begin
            sel = SW'(k + 1);
         end
      end
   end

   assign any_match = |hit;
   assign load_use  = hit[0] && trk[0].is_load;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and hazard detection for the ID stage, DEPTH stages deep.
// Latency: sel_src/hazard are combinational; during sram_freeze they replay the last unfrozen value.
// Backpressure: hazard stalls ID/IF for one bubble; sram_freeze holds tracker and outputs.
// Optional macro FWD_HAZARD_STATS_EN adds saturating fwd_count / stall_count.
// Ports:
//   clk, rst (async, active-low)
//   src/src_valid      - NUM_SRC source indices of the ID instruction
//   id_valid/id_dest/id_wb_en/id_mem_read - the ID instruction itself
//   forward_en         - 1: forward and stall only on load-use; 0: stall on any RAW
//   sram_freeze        - global memory stall
//   sel_src            - per port: 0 = regfile, k = stage k result
//   hazard             - stall ID/IF and inject a bubble
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter  int NUM_SRC = 2,
   parameter  int REG_AW  = 4,
   parameter  int DEPTH   = 3,
   localparam int SW      = sel_width(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC*REG_AW-1:0] src,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic                      id_valid,
   input  logic [REG_AW-1:0]         id_dest,
   input  logic                      id_wb_en,
   input  logic                      id_mem_read,
   input  logic                      forward_en,
   input  logic                      sram_freeze,
   output logic [NUM_SRC*SW-1:0]     sel_src,
   output logic                      hazard
`ifdef FWD_HAZARD_STATS_EN
   ,
   output logic [31:0]               fwd_count,
   output logic [31:0]               stall_count
`endif
);

   trk_entry_t [DEPTH-1:0]  trk;
   trk_entry_t              id_entry;
   logic [NUM_SRC*SW-1:0]   sel_raw;
   logic [NUM_SRC*SW-1:0]   sel_live;
   logic [NUM_SRC*SW-1:0]   sel_hold;
   logic [NUM_SRC-1:0]      port_load_use;
   logic [NUM_SRC-1:0]      port_any_match;
   logic                    haz_live;
   logic                    haz_hold;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
      fwd_port_sel #(
         .REG_AW (REG_AW),
         .DEPTH  (DEPTH),
         .SW     (SW)
      ) u_port_sel (
         .src       (src[i*REG_AW +: REG_AW]),
         .src_valid (src_valid[i]),
         .trk       (trk),
         .sel       (sel_raw[i*SW +: SW]),
         .load_use  (port_load_use[i]),
         .any_match (port_any_match[i])
      );
   end

   // Without forwarding every RAW dependency must wait for the writer to
   // drain; with forwarding only a load still in EX cannot supply its data.
   assign sel_live = forward_en ? sel_raw : '0;
   assign haz_live = forward_en ? (|port_load_use) : (|port_any_match);

   // A frozen pipeline must see the same decisions it saw when it stopped.
   assign sel_src = sram_freeze ? sel_hold : sel_live;
   assign hazard  = sram_freeze ? haz_hold : haz_live;

   // A stalled ID instruction is not admitted; a bubble enters EX instead.
   always_comb begin
      id_entry = '0;
      if (id_valid && !haz_live) begin
         id_entry.valid   = 1'b1;
         id_entry.wb_en   = id_wb_en;
         id_entry.dest    = DEST_W'(id_dest);
         id_entry.is_load = id_mem_read;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trk      <= '0;
         sel_hold <= '0;
         haz_hold <= 1'b0;
      end else if (!sram_freeze) begin
         trk[0] <= id_entry;
         for (int k = 1; k < DEPTH; k++) begin
            trk[k] <= trk[k-1];
         end
         sel_hold <= sel_live;
         haz_hold <= haz_live;
      end
   end

`ifdef FWD_HAZARD_STATS_EN
   // Unfrozen outputs equal the live values, so counting live is exact.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fwd_count   <= '0;
         stall_count <= '0;
      end else if (!sram_freeze) begin
         if ((|sel_live) && (fwd_count != '1)) begin
            fwd_count <= fwd_count + 32'd1;
         end
         if (haz_live && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus random
// traffic compared every cycle against an instruction-level pipeline model.
module tb_fwd_hazard_unit;

   localparam int NUM_SRC = 2;
   localparam int REG_AW  = 4;
   localparam int DEPTH   = 3;
   localparam int SW      = 2;

   logic                      clk = 1'b0;
   logic                      rst = 1'b0;
   logic [NUM_SRC*REG_AW-1:0] src;
   logic [NUM_SRC-1:0]        src_valid;
   logic                      id_valid;
   logic [REG_AW-1:0]         id_dest;
   logic                      id_wb_en;
   logic                      id_mem_read;
   logic                      forward_en;
   logic                      sram_freeze;
   logic [NUM_SRC*SW-1:0]     sel_src;
   logic                      hazard;
`ifdef FWD_HAZARD_STATS_EN
   logic [31:0]               fwd_count;
   logic [31:0]               stall_count;
`endif

   always #5 clk = ~clk;

   fwd_hazard_unit #(
      .NUM_SRC (NUM_SRC),
      .REG_AW  (REG_AW),
      .DEPTH   (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .src         (src),
      .src_valid   (src_valid),
      .id_valid    (id_valid),
      .id_dest     (id_dest),
      .id_wb_en    (id_wb_en),
      .id_mem_read (id_mem_read),
      .forward_en  (forward_en),
      .sram_freeze (sram_freeze),
      .sel_src     (sel_src),
      .hazard      (hazard)
`ifdef FWD_HAZARD_STATS_EN
      ,
      .fwd_count   (fwd_count),
      .stall_count (stall_count)
`endif
   );

   int tests = 0;
   int fails = 0;

   // Model: which instruction sits in each stage (1 = EX ... DEPTH = WB).
   bit     m_v   [1:DEPTH];
   bit     m_wb  [1:DEPTH];
   int     m_dest[1:DEPTH];
   bit     m_ld  [1:DEPTH];
   int     h_sel [NUM_SRC];
   bit     h_haz;
   int     live_sel[NUM_SRC];
   bit     live_haz;
   int     e_sel [NUM_SRC];
   bit     e_haz;
   longint m_fwd;
   longint m_stall;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int src_of(input int i);
      return int'(src[i*REG_AW +: REG_AW]);
   endfunction

   function automatic int dut_sel(input int i);
      return int'(sel_src[i*SW +: SW]);
   endfunction

   task automatic model_reset();
      for (int k = 1; k <= DEPTH; k++) begin
         m_v[k] = 0; m_wb[k] = 0; m_dest[k] = 0; m_ld[k] = 0;
      end
      for (int i = 0; i < NUM_SRC; i++) h_sel[i] = 0;
      h_haz   = 0;
      m_fwd   = 0;
      m_stall = 0;
   endtask

   // Expected outputs from the current model state and inputs.
   task automatic model_eval();
      bit any_dep;
      bit load_dep;
      any_dep  = 0;
      load_dep = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         int youngest;
         youngest = 0;
         for (int k = 1; k <= DEPTH; k++) begin
            if (youngest == 0 && src_valid[i] && m_v[k] && m_wb[k] &&
                m_dest[k] == src_of(i)) youngest = k;
         end
         if (youngest != 0) any_dep = 1;
         if (youngest == 1 && m_ld[1]) load_dep = 1;
         live_sel[i] = forward_en ? youngest : 0;
      end
      live_haz = forward_en ? load_dep : any_dep;
      for (int i = 0; i < NUM_SRC; i++) e_sel[i] = sram_freeze ? h_sel[i] : live_sel[i];
      e_haz = sram_freeze ? h_haz : live_haz;
   endtask

   task automatic model_update();
      bit any_fwd;
      if (!sram_freeze) begin
         any_fwd = 0;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (live_sel[i] != 0) any_fwd = 1;
            h_sel[i] = live_sel[i];
         end
         if (any_fwd && m_fwd < 64'hFFFF_FFFF) m_fwd++;
         if (live_haz && m_stall < 64'hFFFF_FFFF) m_stall++;
         h_haz = live_haz;
         for (int k = DEPTH; k >= 2; k--) begin
            m_v[k] = m_v[k-1]; m_wb[k] = m_wb[k-1];
            m_dest[k] = m_dest[k-1]; m_ld[k] = m_ld[k-1];
         end
         m_v[1]    = id_valid && !live_haz;
         m_wb[1]   = id_wb_en;
         m_dest[1] = int'(id_dest);
         m_ld[1]   = id_mem_read;
      end
   endtask

   task automatic compare_outputs();
      for (int i = 0; i < NUM_SRC; i++)
         check($sformatf("sel_src[%0d]", i), dut_sel(i), e_sel[i]);
      check("hazard", hazard, e_haz);
`ifdef FWD_HAZARD_STATS_EN
      check("fwd_count", fwd_count, m_fwd);
      check("stall_count", stall_count, m_stall);
`endif
   endtask

   // Called just after a falling edge, once inputs are applied.
   task automatic settle();
      #1;
      model_eval();
      compare_outputs();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic set_id(input bit v, input int d, input bit wb, input bit ld);
      id_valid    = v;
      id_dest     = REG_AW'(d);
      id_wb_en    = wb;
      id_mem_read = ld;
   endtask

   task automatic set_src(input int s0, input int s1, input logic [1:0] sv);
      src[0*REG_AW +: REG_AW] = REG_AW'(s0);
      src[1*REG_AW +: REG_AW] = REG_AW'(s1);
      src_valid = sv;
   endtask

   task automatic flush();
      set_id(0, 0, 0, 0);
      set_src(0, 0, 2'b00);
      sram_freeze = 0;
      repeat (DEPTH) begin
         settle();
         advance();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sel_src"}, sel_src, 0);
      check({tag, "_hazard"}, hazard, 0);
`ifdef FWD_HAZARD_STATS_EN
      check({tag, "_fwd_count"}, fwd_count, 0);
      check({tag, "_stall_count"}, stall_count, 0);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      src = '0; src_valid = '0;
      set_id(0, 0, 0, 0);
      forward_en = 1; sram_freeze = 0;
      model_reset();

      // Outputs idle while in reset, even with a would-be matching request.
      set_src(3, 3, 2'b11);
      set_id(1, 3, 1, 1);
      #1;
      check_reset_outputs("in_reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1;

      // EX forward; also the first edge after reset is a normal shift.
      set_src(0, 0, 2'b00);
      set_id(1, 3, 1, 0);
      settle();
      advance();
      set_id(0, 0, 0, 0);
      set_src(3, 0, 2'b01);
      settle();
      check("ex_fwd_sel0", dut_sel(0), 1);
      check("ex_fwd_hazard", hazard, 0);
      check("ex_fwd_model", e_sel[0], 1);
      advance();
      flush();

      // Youngest of two writers wins.
      set_id(1, 5, 1, 0);
      settle(); advance();
      settle(); advance();
      set_id(0, 0, 0, 0);
      set_src(0, 5, 2'b10);
      settle();
      check("youngest_sel1", dut_sel(1), 1);
      check("youngest_hazard", hazard, 0);
      advance();
      flush();

      // Load-use: one stall cycle, then forward from MEM.
      set_id(1, 2, 1, 1);
      settle(); advance();
      set_src(2, 0, 2'b01);
      set_id(1, 7, 1, 0);
      settle();
      check("load_use_hazard", hazard, 1);
      check("load_use_model", e_haz, 1);
      advance();
      settle();
      check("load_use_after_hazard", hazard, 0);
      check("load_use_after_sel0", dut_sel(0), 2);
      advance();
      flush();

      // Freeze holds outputs and tracker while inputs change.
      set_id(1, 3, 1, 0);
      settle(); advance();
      set_id(0, 0, 0, 0);
      set_src(3, 0, 2'b01);
      settle();
      check("pre_freeze_sel0", dut_sel(0), 1);
      advance();
      sram_freeze = 1;
      for (int c = 0; c < 3; c++) begin
         set_src(9 + c, 3, 2'b11);
         set_id(1, 3, 1, 1);
         settle();
         check($sformatf("freeze%0d_sel0", c), dut_sel(0), 1);
         check($sformatf("freeze%0d_hazard", c), hazard, 0);
         advance();
      end
      sram_freeze = 0;
      set_id(0, 0, 0, 0);
      set_src(3, 0, 2'b01);
      settle();
      check("freeze_release_sel0", dut_sel(0), 2);
      advance();
      flush();

      // Forwarding off: stall until the stage-3 writer drains.
      forward_en = 0;
      set_id(1, 6, 1, 0);
      settle(); advance();
      set_id(0, 0, 0, 0);
      settle(); advance();
      settle(); advance();
      set_src(6, 0, 2'b01);
      settle();
      check("nofwd_sel0", dut_sel(0), 0);
      check("nofwd_hazard", hazard, 1);
      advance();
      settle();
      check("nofwd_drained_hazard", hazard, 0);
      advance();
      forward_en = 1;
      flush();

      // Asynchronous reset in the middle of a load-use stall.
      set_id(1, 2, 1, 1);
      settle(); advance();
      set_src(2, 0, 2'b01);
      set_id(1, 7, 1, 0);
      settle();
      check("pre_reset_hazard", hazard, 1);
      #2 rst = 0;
      #1;
      model_reset();
      check_reset_outputs("mid_stall_reset");
      @(posedge clk);
      @(negedge clk);
      rst = 1;

      // Random traffic over a small register range to force collisions.
      for (int n = 0; n < 1500; n++) begin
         set_src($urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)));
         set_id($urandom_range(0, 9) < 7, $urandom_range(0, 3),
                $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4);
         forward_en  = $urandom_range(0, 19) < 17;
         sram_freeze = $urandom_range(0, 19) < 3;
         settle();
         if ($urandom_range(0, 199) == 0) begin
            #2 rst = 0;
            #1;
            model_reset();
            check_reset_outputs("rand_reset");
            @(posedge clk);
            @(negedge clk);
            rst = 1;
         end else begin
            advance();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
